time_entry_ctrl: RTL and testbench

Parametrised user time-entry controller feeding the stopwatch/clock datapath. It holds four editable fields: milliseconds, seconds, minutes and hours. Each field steps up or down by a programmable amount with exact modulo wrap, and carry/borrow between fields is optional. An explicit commit/cancel handshake loads the edited time downstream as a single-cycle pulse.

---
 rtl/time_entry_pkg.sv | 31 +++
 rtl/time_field_step.sv | 59 +++++
 rtl/time_entry_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_time_entry_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/time_entry_pkg.sv
// time_entry_pkg: shared field-select codes, FSM state type and default moduli
// Latency: n/a (declarations only)
// Backpressure: n/a
package time_entry_pkg;

  // Field-select encoding driven on sel
  localparam logic [1:0] FLD_MS  = 2'd0;
  localparam logic [1:0] FLD_SEC = 2'd1;
  localparam logic [1:0] FLD_MIN = 2'd2;
  localparam logic [1:0] FLD_HR  = 2'd3;

  // Edit controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Default moduli for a 24-hour clock with millisecond resolution
  localparam int MS_MAX_DEF  = 1000;
  localparam int SEC_MAX_DEF = 60;
  localparam int MIN_MAX_DEF = 60;
  localparam int HR_MAX_DEF  = 24;
  localparam int STEP_W_DEF  = 4;

  // True when the select code addresses the given field
  function automatic logic fld_hit(input logic [1:0] sel_f, input logic [1:0] fld);
    return (sel_f == fld);
  endfunction

endpackage

// File: rtl/time_field_step.sv
// time_field_step: one modulo-MAX time field stepped up/down by a variable amount
// Latency: combinational (0 cycles); the caller registers v_next
// Backpressure: none; the result is valid whenever the inputs are
//
// Ports:
//   v        current field value (0..MAX-1)
//   step     amount for an own inc/dec
//   inc/dec  own step request (both high = no change)
//   cin_inc  carry-in from the field below: add 1
//   cin_dec  borrow-in from the field below: subtract 1
//   v_next   updated value
//   wrap     increment crossed MAX (carry out)
//   borrow   decrement went below 0 (borrow out)
module time_field_step import time_entry_pkg::*; #(
  parameter int MAX    = 60,
  parameter int STEP_W = 4,
  parameter int W      = $clog2(MAX)
) (
  input  logic [W-1:0]      v,
  input  logic [STEP_W-1:0] step,
  input  logic              inc,
  input  logic              dec,
  input  logic              cin_inc,
  input  logic              cin_dec,
  output logic [W-1:0]      v_next,
  output logic              wrap,
  output logic              borrow
);

  // One extra bit so v + step and v + MAX - amt never overflow
  localparam logic [W:0] MAX_X = (W+1)'(MAX);

  logic         w_add;
  logic         w_sub;
  logic [W:0]   w_v_x;
  logic [W:0]   w_amt_x;
  logic [W:0]   w_sum;

  always_comb begin
    // A field is either the selected one (own step) or receives a carry of 1;
    // both cannot happen together because carries only travel upward.
    w_add   = (inc & ~dec) | cin_inc;
    w_sub   = (dec & ~inc) | cin_dec;
    w_v_x   = {1'b0, v};
    w_amt_x = (inc ^ dec) ? {{(W+1-STEP_W){1'b0}}, step} : (W+1)'(1);
    w_sum   = w_v_x + w_amt_x;

    wrap   = w_add & (w_sum >= MAX_X);
    borrow = w_sub & (w_v_x < w_amt_x);

    v_next = v;
    if (w_add) begin
      v_next = wrap ? W'(w_sum - MAX_X) : W'(w_sum);
    end else if (w_sub) begin
      v_next = borrow ? W'(w_v_x + MAX_X - w_amt_x) : W'(w_v_x - w_amt_x);
    end
  end

endmodule

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: editable ms/sec/min/hr fields with commit/cancel handshake
// Latency: inc/dec -> *_o after 1 edge; commit -> load_o pulse after 1 edge
// Backpressure: none; inc/dec ignored during the COMMIT cycle, commit/cancel ignored in IDLE
//
// Build option: define TIME_ENTRY_CARRY_EN to ripple wrap/borrow into higher fields
// (out of hr is discarded); undefined, every field wraps on its own.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   sel                  field select (FLD_MS/FLD_SEC/FLD_MIN/FLD_HR)
//   step                 amount per inc/dec cycle
//   inc, dec             step selected field (both = no effect)
//   commit, cancel       accept edits / restore last committed time (EDIT only)
//   ms_o..hr_o           current edit values
//   editing_o            high while in EDIT
//   load_o               one-cycle pulse; *_o carry the committed time then
module time_entry_ctrl import time_entry_pkg::*; #(
  parameter int MS_MAX  = MS_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int HR_MAX  = HR_MAX_DEF,
  parameter int STEP_W  = STEP_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 sel,
  input  logic [STEP_W-1:0]          step,
  input  logic                       inc,
  input  logic                       dec,
  input  logic                       commit,
  input  logic                       cancel,
  output logic [$clog2(MS_MAX)-1:0]  ms_o,
  output logic [$clog2(SEC_MAX)-1:0] sec_o,
  output logic [$clog2(MIN_MAX)-1:0] min_o,
  output logic [$clog2(HR_MAX)-1:0]  hr_o,
  output logic                       editing_o,
  output logic                       load_o
);

  localparam int MS_W  = $clog2(MS_MAX);
  localparam int SEC_W = $clog2(SEC_MAX);
  localparam int MIN_W = $clog2(MIN_MAX);
  localparam int HR_W  = $clog2(HR_MAX);

  // FSM
  state_t r_state;
  state_t w_state_nxt;
  logic   w_eff;        // exactly one of inc/dec
  logic   w_step_en;    // apply field step this cycle
  logic   w_cancel_en;  // restore shadow into edit registers
  logic   w_shadow_en;  // capture edit registers into shadow

  // Edit and shadow registers
  logic [MS_W-1:0]  r_ms,    r_sh_ms;
  logic [SEC_W-1:0] r_sec,   r_sh_sec;
  logic [MIN_W-1:0] r_min,   r_sh_min;
  logic [HR_W-1:0]  r_hr,    r_sh_hr;

  // Field step unit wiring
  logic w_inc_ms,  w_dec_ms;
  logic w_inc_sec, w_dec_sec;
  logic w_inc_min, w_dec_min;
  logic w_inc_hr,  w_dec_hr;
  logic w_cin_inc_sec, w_cin_dec_sec;
  logic w_cin_inc_min, w_cin_dec_min;
  logic w_cin_inc_hr,  w_cin_dec_hr;
  logic w_wrap_ms,  w_borrow_ms;
  logic w_wrap_sec, w_borrow_sec;
  logic w_wrap_min, w_borrow_min;
  logic w_wrap_hr,  w_borrow_hr;
  logic [MS_W-1:0]  w_ms_nxt;
  logic [SEC_W-1:0] w_sec_nxt;
  logic [MIN_W-1:0] w_min_nxt;
  logic [HR_W-1:0]  w_hr_nxt;

  assign w_eff = inc ^ dec;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state (cancel beats commit beats inc/dec)
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_eff) w_state_nxt = ST_EDIT;
      end
      ST_EDIT: begin
        if (cancel)      w_state_nxt = ST_IDLE;
        else if (commit) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes, decoded from the registered state only
  always_comb begin
    editing_o   = 1'b0;
    load_o      = 1'b0;
    w_step_en   = 1'b0;
    w_cancel_en = 1'b0;
    w_shadow_en = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_step_en = w_eff;
      end
      ST_EDIT: begin
        editing_o   = 1'b1;
        w_cancel_en = cancel;
        // A step arriving with commit/cancel is dropped
        w_step_en   = w_eff & ~cancel & ~commit;
      end
      ST_COMMIT: begin
        load_o      = 1'b1;
        w_shadow_en = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Field step requests
  // ---------------------------------------------------------------------------
  always_comb begin
    w_inc_ms  = w_step_en & inc & fld_hit(sel, FLD_MS);
    w_dec_ms  = w_step_en & dec & fld_hit(sel, FLD_MS);
    w_inc_sec = w_step_en & inc & fld_hit(sel, FLD_SEC);
    w_dec_sec = w_step_en & dec & fld_hit(sel, FLD_SEC);
    w_inc_min = w_step_en & inc & fld_hit(sel, FLD_MIN);
    w_dec_min = w_step_en & dec & fld_hit(sel, FLD_MIN);
    w_inc_hr  = w_step_en & inc & fld_hit(sel, FLD_HR);
    w_dec_hr  = w_step_en & dec & fld_hit(sel, FLD_HR);
  end

`ifdef TIME_ENTRY_CARRY_EN
  // Carry/borrow ripples combinationally up the chain in one cycle
  assign w_cin_inc_sec = w_wrap_ms;
  assign w_cin_dec_sec = w_borrow_ms;
  assign w_cin_inc_min = w_wrap_sec;
  assign w_cin_dec_min = w_borrow_sec;
  assign w_cin_inc_hr  = w_wrap_min;
  assign w_cin_dec_hr  = w_borrow_min;
`else
  assign w_cin_inc_sec = 1'b0;
  assign w_cin_dec_sec = 1'b0;
  assign w_cin_inc_min = 1'b0;
  assign w_cin_dec_min = 1'b0;
  assign w_cin_inc_hr  = 1'b0;
  assign w_cin_dec_hr  = 1'b0;
`endif

  // Carry out of hr is always dropped; lower ones are dropped without carry chaining
  logic w_unused_carry;
  assign w_unused_carry = ^{w_wrap_ms, w_borrow_ms, w_wrap_sec, w_borrow_sec,
                            w_wrap_min, w_borrow_min, w_wrap_hr, w_borrow_hr};

  time_field_step #(.MAX(MS_MAX), .STEP_W(STEP_W)) u_ms (
    .v(r_ms), .step(step), .inc(w_inc_ms), .dec(w_dec_ms),
    .cin_inc(1'b0), .cin_dec(1'b0),
    .v_next(w_ms_nxt), .wrap(w_wrap_ms), .borrow(w_borrow_ms)
  );

  time_field_step #(.MAX(SEC_MAX), .STEP_W(STEP_W)) u_sec (
    .v(r_sec), .step(step), .inc(w_inc_sec), .dec(w_dec_sec),
    .cin_inc(w_cin_inc_sec), .cin_dec(w_cin_dec_sec),
    .v_next(w_sec_nxt), .wrap(w_wrap_sec), .borrow(w_borrow_sec)
  );

  time_field_step #(.MAX(MIN_MAX), .STEP_W(STEP_W)) u_min (
    .v(r_min), .step(step), .inc(w_inc_min), .dec(w_dec_min),
    .cin_inc(w_cin_inc_min), .cin_dec(w_cin_dec_min),
    .v_next(w_min_nxt), .wrap(w_wrap_min), .borrow(w_borrow_min)
  );

  time_field_step #(.MAX(HR_MAX), .STEP_W(STEP_W)) u_hr (
    .v(r_hr), .step(step), .inc(w_inc_hr), .dec(w_dec_hr),
    .cin_inc(w_cin_inc_hr), .cin_dec(w_cin_dec_hr),
    .v_next(w_hr_nxt), .wrap(w_wrap_hr), .borrow(w_borrow_hr)
  );

  // ---------------------------------------------------------------------------
  // Edit and shadow registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms     <= '0;
      r_sec    <= '0;
      r_min    <= '0;
      r_hr     <= '0;
      r_sh_ms  <= '0;
      r_sh_sec <= '0;
      r_sh_min <= '0;
      r_sh_hr  <= '0;
    end else begin
      if (w_cancel_en) begin
        r_ms  <= r_sh_ms;
        r_sec <= r_sh_sec;
        r_min <= r_sh_min;
        r_hr  <= r_sh_hr;
      end else if (w_step_en) begin
        r_ms  <= w_ms_nxt;
        r_sec <= w_sec_nxt;
        r_min <= w_min_nxt;
        r_hr  <= w_hr_nxt;
      end
      // Edit registers are frozen in COMMIT, so this captures the loaded time
      if (w_shadow_en) begin
        r_sh_ms  <= r_ms;
        r_sh_sec <= r_sec;
        r_sh_min <= r_min;
        r_sh_hr  <= r_hr;
      end
    end
  end

  assign ms_o  = r_ms;
  assign sec_o = r_sec;
  assign min_o = r_min;
  assign hr_o  = r_hr;

endmodule

// File: tb/tb_time_entry_ctrl.sv
module tb_time_entry_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [3:0] step = 4'd0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       commit = 1'b0;
  logic       cancel = 1'b0;
  logic [9:0] ms_o;
  logic [5:0] sec_o;
  logic [5:0] min_o;
  logic [4:0] hr_o;
  logic       editing_o;
  logic       load_o;

  time_entry_ctrl dut (
    .clk(clk), .reset(reset), .sel(sel), .step(step),
    .inc(inc), .dec(dec), .commit(commit), .cancel(cancel),
    .ms_o(ms_o), .sec_o(sec_o), .min_o(min_o), .hr_o(hr_o),
    .editing_o(editing_o), .load_o(load_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: fields indexed ms=0, sec=1, min=2, hr=3
  int mods[4] = '{1000, 60, 60, 24};
  int m_edit[4];
  int m_shadow[4];
  int m_mode;  // 0 idle, 1 editing, 2 loading

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Step one field by amt; with carry enabled the four fields act as one
  // mixed-radix number, so the step is plain modular arithmetic on the total.
  task automatic model_apply(input int s, input int amt, input bit up);
`ifdef TIME_ENTRY_CARRY_EN
    longint tot, wgt, span;
    tot = 0; span = 1; wgt = 1;
    for (int i = 3; i >= 0; i--) tot = tot * mods[i] + m_edit[i];
    for (int i = 0; i < 4; i++) span = span * mods[i];
    for (int i = 0; i < s; i++) wgt = wgt * mods[i];
    if (up) tot = (tot + longint'(amt) * wgt) % span;
    else    tot = (tot + span - longint'(amt) * wgt) % span;
    for (int i = 0; i < 4; i++) begin
      m_edit[i] = int'(tot % mods[i]);
      tot = tot / mods[i];
    end
`else
    if (up) m_edit[s] = (m_edit[s] + amt) % mods[s];
    else    m_edit[s] = (m_edit[s] + mods[s] - amt) % mods[s];
`endif
  endtask

  task automatic model_edge(input bit rst, input int s, input int st, input bit i, input bit d,
                            input bit cm, input bit cn);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin m_edit[k] = 0; m_shadow[k] = 0; end
      m_mode = 0;
    end else if (m_mode == 2) begin
      for (int k = 0; k < 4; k++) m_shadow[k] = m_edit[k];
      m_mode = 0;
    end else if (m_mode == 1 && cn) begin
      for (int k = 0; k < 4; k++) m_edit[k] = m_shadow[k];
      m_mode = 0;
    end else if (m_mode == 1 && cm) begin
      m_mode = 2;
    end else if (i != d) begin
      model_apply(s, st, i);
      m_mode = 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare all outputs
  task automatic cyc(input bit rst, input int s, input int st, input bit i, input bit d,
                     input bit cm, input bit cn);
    reset = rst; sel = 2'(s); step = 4'(st); inc = i; dec = d; commit = cm; cancel = cn;
    @(posedge clk);
    model_edge(rst, s, st, i, d, cm, cn);
    #1;
    chk("ms_o",      32'(ms_o),      32'(m_edit[0]));
    chk("sec_o",     32'(sec_o),     32'(m_edit[1]));
    chk("min_o",     32'(min_o),     32'(m_edit[2]));
    chk("hr_o",      32'(hr_o),      32'(m_edit[3]));
    chk("editing_o", 32'(editing_o), 32'(m_mode == 1));
    chk("load_o",    32'(load_o),    32'(m_mode == 2));
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog expired observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) begin m_edit[k] = 0; m_shadow[k] = 0; end
    m_mode = 0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_ms", 32'(ms_o), 0);
    chk("reset_hr", 32'(hr_o), 0);
    chk("reset_editing", 32'(editing_o), 0);
    chk("reset_load", 32'(load_o), 0);

    // sec += 9 seven times -> 63 mod 60
    for (int k = 0; k < 7; k++) cyc(0, 1, 9, 1, 0, 0, 0);
    chk("sec_7x9", 32'(sec_o), 3);
    chk("sec_7x9_editing", 32'(editing_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("cancel_to_zero_sec", 32'(sec_o), 0);

    // ms 995 + 8 wraps to 3
    cyc(0, 0, 5, 0, 1, 0, 0);
    chk("ms_dec_to_995", 32'(ms_o), 995);
    cyc(0, 0, 8, 1, 0, 0, 0);
    chk("ms_wrap_to_3", 32'(ms_o), 3);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // hr 0 - 5 -> 19
    cyc(0, 3, 5, 0, 1, 0, 0);
    chk("hr_borrow_19", 32'(hr_o), 19);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("hr_after_cancel", 32'(hr_o), 0);

`ifdef TIME_ENTRY_CARRY_EN
    // Full borrow chain from all-zero
    cyc(0, 0, 1, 0, 1, 0, 0);
    chk("chain_ms", 32'(ms_o), 999);
    chk("chain_sec", 32'(sec_o), 59);
    chk("chain_min", 32'(min_o), 59);
    chk("chain_hr", 32'(hr_o), 23);
    cyc(0, 0, 0, 0, 0, 0, 1);
`endif

    // Edit to 00:12:34.500 and commit
    cyc(0, 2, 12, 1, 0, 0, 0);
    cyc(0, 1, 15, 1, 0, 0, 0);
    cyc(0, 1, 15, 1, 0, 0, 0);
    cyc(0, 1, 4, 1, 0, 0, 0);
    for (int k = 0; k < 33; k++) cyc(0, 0, 15, 1, 0, 0, 0);
    cyc(0, 0, 5, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("commit_load", 32'(load_o), 1);
    chk("commit_ms", 32'(ms_o), 500);
    chk("commit_sec", 32'(sec_o), 34);
    chk("commit_min", 32'(min_o), 12);
    chk("commit_hr", 32'(hr_o), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("load_one_cycle", 32'(load_o), 0);

    // Further edit, then cancel restores the committed time
    cyc(0, 2, 7, 1, 0, 0, 0);
    chk("edit_min_19", 32'(min_o), 19);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("cancel_min", 32'(min_o), 12);
    chk("cancel_ms", 32'(ms_o), 500);
    chk("cancel_no_load", 32'(load_o), 0);

    // inc and dec together: nothing happens
    cyc(0, 0, 3, 1, 1, 0, 0);
    chk("incdec_editing", 32'(editing_o), 0);
    chk("incdec_ms", 32'(ms_o), 500);

    // commit with inc in EDIT: commit wins, step lost
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    chk("commit_beats_inc_ms", 32'(ms_o), 501);
    chk("commit_beats_inc_load", 32'(load_o), 1);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("inc_in_commit_ignored", 32'(ms_o), 501);

    // Reset during COMMIT clears everything, including the shadow
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("pre_reset_load", 32'(load_o), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_in_commit_load", 32'(load_o), 0);
    chk("reset_in_commit_ms", 32'(ms_o), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 3, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("shadow_cleared_sec", 32'(sec_o), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit r_rst, r_i, r_d, r_cm, r_cn;
      r_rst = ($urandom_range(0, 199) == 0);
      r_i   = ($urandom_range(0, 99) < 55);
      r_d   = ($urandom_range(0, 99) < 40);
      r_cm  = ($urandom_range(0, 9) == 0);
      r_cn  = ($urandom_range(0, 14) == 0);
      cyc(r_rst, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), r_i, r_d, r_cm, r_cn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
